// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared state encoding and default sizes for the music playback sequencer
package music_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int TICK_DIV_DEF = 4194304;
    localparam int LEN_A_DEF    = 512;
    localparam int LEN_B_DEF    = 256;
    localparam int BEAT_W_DEF   = 12;

endpackage

// File: rtl/beat_prescaler.sv
// rtl/beat_prescaler.sv - clk-cycle prescaler issuing one tick per beat period (normal or half rate)
import music_pkg::*;

module beat_prescaler #(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    input  logic slow,
    output logic tick
);

    localparam int CW = $clog2(2 * TICK_DIV);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last;

    assign last = slow ? CW'(2 * TICK_DIV - 1) : CW'(TICK_DIV - 1);

    // ">=" keeps a half-rate count above the normal limit from overshooting when slow drops
    assign tick = run && (cnt >= last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/beat_scheduler.sv
// rtl/beat_scheduler.sv - play/pause/slow/loop beat sequencer driving the music ROM index and note enable
// Optional reverse playback: define BEAT_SCHED_REVERSE_EN to add the _reverse input.
import music_pkg::*;

module beat_scheduler #(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int LEN_A    = LEN_A_DEF,
    parameter int LEN_B    = LEN_B_DEF,
    parameter int BEAT_W   = BEAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              _play,
    input  logic              _slow,
    input  logic              _music,
    input  logic              _mode,
`ifdef BEAT_SCHED_REVERSE_EN
    input  logic              _reverse,
`endif
    output logic [BEAT_W-1:0] ibeat,
    output logic              beat_tick,
    output logic              en,
    output logic              done
);

    state_t            state;
    state_t            nxt_state;
    logic [BEAT_W-1:0] nxt_ibeat;
    logic              nxt_tick;
    logic              music_q;
    logic              chg;
    logic              run;
    logic              clear;
    logic              tick;
    logic              rev;
    logic [BEAT_W-1:0] len_m1;

`ifdef BEAT_SCHED_REVERSE_EN
    assign rev = _reverse;
`else
    assign rev = 1'b0;
`endif

    assign len_m1 = music_q ? BEAT_W'(LEN_B - 1) : BEAT_W'(LEN_A - 1);
    assign chg    = (_music != music_q) && (state != IDLE);

    // a track change or a pause request in this cycle swallows any tick that was due
    assign run   = (state == PLAY) && _play && !chg;
    assign clear = chg || (state == IDLE) || (state == DONE);

    beat_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clear(clear),
        .slow (_slow),
        .tick (tick)
    );

    always_comb begin
        nxt_state = state;
        nxt_ibeat = ibeat;
        nxt_tick  = 1'b0;
        if (chg) begin
            nxt_ibeat = rev ? len_m1 : '0;
            if (state == DONE && _play) begin
                nxt_state = PLAY;
            end
        end else begin
            case (state)
                IDLE: begin
                    nxt_ibeat = '0;
                    if (_play) begin
                        nxt_state = PLAY;
                    end
                end
                PLAY: begin
                    if (!_play) begin
                        nxt_state = PAUSE;
                    end else if (tick) begin
                        nxt_tick = 1'b1;
                        if (rev) begin
                            if (ibeat == '0) begin
                                if (_mode) begin
                                    nxt_ibeat = len_m1;
                                end else begin
                                    nxt_state = DONE;
                                end
                            end else if (ibeat > len_m1) begin
                                nxt_ibeat = len_m1;
                            end else begin
                                nxt_ibeat = ibeat - BEAT_W'(1);
                            end
                        end else if (ibeat < len_m1) begin
                            nxt_ibeat = ibeat + BEAT_W'(1);
                        end else if (_mode) begin
                            nxt_ibeat = '0;
                        end else begin
                            nxt_state = DONE;
                            nxt_ibeat = len_m1;
                        end
                    end
                end
                PAUSE: begin
                    if (_play) begin
                        nxt_state = PLAY;
                    end
                end
                DONE: begin
                    if (!_play) begin
                        nxt_state = IDLE;
                        nxt_ibeat = '0;
                    end else if (_mode) begin
                        nxt_state = PLAY;
                        nxt_ibeat = '0;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_ibeat = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ibeat     <= '0;
            beat_tick <= 1'b0;
            en        <= 1'b0;
            done      <= 1'b0;
            music_q   <= 1'b0;
        end else begin
            state     <= nxt_state;
            ibeat     <= nxt_ibeat;
            beat_tick <= nxt_tick;
            en        <= (nxt_state == PLAY);
            done      <= (nxt_state == DONE);
            music_q   <= _music;
        end
    end

endmodule

// File: tb/tb_beat_scheduler.sv
// tb/tb_beat_scheduler.sv - randomized self-checking bench for beat_scheduler against a beat-level reference model
module tb_beat_scheduler;

    localparam int TD = 4;
    localparam int LA = 8;
    localparam int LB = 4;
    localparam int BW = 4;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          p, s, m, md;
    logic [BW-1:0] ibeat;
    logic          beat_tick, en, done;
`ifdef BEAT_SCHED_REVERSE_EN
    logic          rv = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    int mst, mbeat, mph, mpm, mtick;

    beat_scheduler #(
        .TICK_DIV(TD),
        .LEN_A   (LA),
        .LEN_B   (LB),
        .BEAT_W  (BW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        ._play    (p),
        ._slow    (s),
        ._music   (m),
        ._mode    (md),
`ifdef BEAT_SCHED_REVERSE_EN
        ._reverse (rv),
`endif
        .ibeat    (ibeat),
        .beat_tick(beat_tick),
        .en       (en),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mst = M_IDLE; mbeat = 0; mph = 0; mpm = 0; mtick = 0;
    endtask

    // one clock edge of the behavioural model; mph counts cycles already spent in the current beat
    task automatic model_step();
        int len, per;
        len   = (mpm != 0) ? LB : LA;
        per   = s ? 2 * TD : TD;
        mtick = 0;
        if ((int'(m) != mpm) && mst != M_IDLE) begin
            mbeat = 0;
            mph   = 0;
            if (mst == M_DONE && p) mst = M_PLAY;
        end else begin
            case (mst)
                M_IDLE: begin
                    mbeat = 0; mph = 0;
                    if (p) mst = M_PLAY;
                end
                M_PLAY: begin
                    if (!p) begin
                        mst = M_PAUSE;
                    end else if (mph + 1 >= per) begin
                        mph   = 0;
                        mtick = 1;
                        if (mbeat + 1 < len) mbeat = mbeat + 1;
                        else if (md) mbeat = 0;
                        else begin mst = M_DONE; mbeat = len - 1; end
                    end else begin
                        mph = mph + 1;
                    end
                end
                M_PAUSE: if (p) mst = M_PLAY;
                default: begin
                    mph = 0;
                    if (!p) begin mst = M_IDLE; mbeat = 0; end
                    else if (md) begin mst = M_PLAY; mbeat = 0; end
                end
            endcase
        end
        mpm = int'(m);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        check("ibeat", int'(ibeat), mbeat);
        check("beat_tick", int'(beat_tick), mtick);
        check("en", int'(en), (mst == M_PLAY) ? 1 : 0);
        check("done", int'(done), (mst == M_DONE) ? 1 : 0);
    endtask

    initial begin
        rst = 1'b0; p = 1'b0; s = 1'b0; m = 1'b0; md = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ibeat", int'(ibeat), 0);
        check("rst_tick", int'(beat_tick), 0);
        check("rst_en", int'(en), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b1;

        p = 1'b1; md = 1'b1;
        repeat (40) cycle();

        m = 1'b1; md = 1'b0;
        repeat (20) cycle();
        check("oneshot_done", int'(done), 1);
        check("oneshot_ibeat", int'(ibeat), LB - 1);
        check("oneshot_en", int'(en), 0);
        p = 1'b0;
        cycle();
        check("stop_ibeat", int'(ibeat), 0);
        check("stop_done", int'(done), 0);

        p = 1'b1; md = 1'b1; m = 1'b0;
        repeat (3) cycle();
        p = 1'b0;
        repeat (10) cycle();
        p = 1'b1;
        repeat (3) cycle();
        s = 1'b1;
        repeat (22) cycle();
        s = 1'b0;
        repeat (10) cycle();

        repeat (3000) begin
            if ($urandom_range(0, 49) == 0) p = ~p;
            if ($urandom_range(0, 24) == 0) s = ~s;
            if ($urandom_range(0, 99) == 0) m = ~m;
            if ($urandom_range(0, 79) == 0) md = ~md;
            cycle();
        end

        p = 1'b1; md = 1'b1;
        repeat (6) cycle();
        check("pre_reset_en", int'(en), 1);
        #2 rst = 1'b0;
        #1;
        check("async_ibeat", int'(ibeat), 0);
        check("async_tick", int'(beat_tick), 0);
        check("async_en", int'(en), 0);
        check("async_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        p = 1'b0;
        cycle();
        p = 1'b1;
        repeat (12) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
